// File: rtl/acc_core.sv
// rtl/acc_core.sv - accumulator core: multi-cycle FSM with register file, external ALU, divider and memory
module acc_core #(
  parameter int          WIDTH    = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] from_mem,
  output logic [WIDTH-1:0] to_mem,
  output logic             mem_req,
  output logic             mem_write,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       S,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] dA,
  output logic [WIDTH-1:0] dB,
  output logic             div_start,
  input  logic [WIDTH-1:0] Q,
  input  logic             div_complete,
  output logic             halted,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] LP_RESET_PC = WIDTH'(RESET_PC);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_DIV, S_HALT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_regs [0:7];
  logic [7:0]       r_ir;
  logic             r_run;
  logic             r_div_start;
  logic [WIDTH-1:0] r_da;
  logic [WIDTH-1:0] r_db;
  logic             r_illegal;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [7:0]       w_ir_nxt;
  logic             w_rf_we;
  logic             w_enter_div;
  logic             w_illegal_nxt;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_off;

  assign w_idx     = r_ir[2:0];
  assign w_off     = {{(WIDTH-4){r_ir[3]}}, r_ir[3:0]};
  assign A         = r_acc;
  assign B         = r_regs[w_idx];
  assign S         = r_ir[5:3];
  assign dA        = r_da;
  assign dB        = r_db;
  assign div_start = r_div_start;
  assign halted    = (r_state == S_HALT);
  assign illegal   = r_illegal;

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_pc_nxt      = r_regs[7];
    w_ir_nxt      = r_ir;
    w_rf_we       = 1'b0;
    w_enter_div   = 1'b0;
    w_illegal_nxt = r_illegal;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    address       = r_regs[7];
    to_mem        = '0;
    case (r_state)
      S_FETCH: begin
        // r_run keeps the first request off until the first edge after reset
        mem_req = r_run;
        if (r_run && mem_ready) begin
          w_ir_nxt    = from_mem[7:0];
          w_pc_nxt    = r_regs[7] + WIDTH'(1);
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (r_ir[7:4])
          4'b0000, 4'b0001, 4'b0010, 4'b0011: w_acc_nxt = D;
          4'b0100: w_pc_nxt = r_regs[7] + w_off;
          4'b0101: if (r_acc == '0) w_pc_nxt = r_regs[7] + w_off;
          4'b0110: if (!r_acc[WIDTH-1]) w_pc_nxt = r_regs[7] + w_off;
          4'b1001: begin
            w_state_nxt = S_DIV;
            w_enter_div = 1'b1;
          end
          4'b1010: w_state_nxt = S_HALT;
          4'b1100: w_acc_nxt = {r_acc[WIDTH-1:4], r_ir[3:0]};
          4'b1101: begin
            if (!r_ir[3])         w_acc_nxt = r_regs[w_idx];
            else if (w_idx == 3'd7) w_pc_nxt = r_acc;
            else                  w_rf_we   = 1'b1;
          end
          4'b1110: w_state_nxt = S_MEM;
          4'b1111: ;
          default: begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        address   = r_regs[w_idx];
        mem_write = r_ir[3];
        to_mem    = r_ir[3] ? r_acc : '0;
        if (mem_ready) begin
          if (!r_ir[3]) w_acc_nxt = from_mem;
          w_state_nxt = S_FETCH;
        end
      end
      S_DIV: begin
        if (div_complete) begin
          w_acc_nxt   = Q;
          w_state_nxt = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_acc       <= '0;
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      r_regs[7]   <= LP_RESET_PC;
      r_ir        <= 8'hFF;
      r_run       <= 1'b0;
      r_div_start <= 1'b0;
      r_da        <= '0;
      r_db        <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_ir        <= w_ir_nxt;
      r_regs[7]   <= w_pc_nxt;
      if (w_rf_we) r_regs[w_idx] <= r_acc;
      r_div_start <= w_enter_div;
      if (w_enter_div) begin
        r_da <= r_acc;
        r_db <= r_regs[w_idx];
      end
      r_illegal   <= w_illegal_nxt;
    end
  end

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - scoreboard testbench for acc_core with memory, ALU and divider models
module tb_acc_core;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] address, from_mem, to_mem, A, B, D, dA, dB, Q;
  logic         mem_req, mem_write, mem_ready, div_start, div_complete, halted, illegal;
  logic [2:0]   S;
  logic [7:0]   mem [256];
  logic [15:0]  obs_rd [$];
  logic [15:0]  obs_wr [$];
  logic [15:0]  exp_q  [$];
  int           n_start = 0;
  int           errors = 0;
  int           checks = 0;

  always #5 clock = ~clock;

  assign from_mem = mem[address];
  // ALU model: S=0 adds, S=1 shifts left by a nibble
  assign D = (S == 3'd0) ? A + B : (S == 3'd1) ? (A << 4) : '0;

  always @(posedge clock) begin
    if (!reset && mem_req && mem_ready) begin
      if (mem_write) obs_wr.push_back({address, to_mem});
      else           obs_rd.push_back({8'h00, address});
    end
    if (div_start) n_start <= n_start + 1;
  end

  acc_core #(.WIDTH(W), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset), .address(address), .from_mem(from_mem), .to_mem(to_mem),
    .mem_req(mem_req), .mem_write(mem_write), .mem_ready(mem_ready), .A(A), .B(B), .S(S), .D(D),
    .dA(dA), .dB(dB), .div_start(div_start), .Q(Q), .div_complete(div_complete),
    .halted(halted), .illegal(illegal)
  );

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; div_complete = 1'b0; Q = '0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_div(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (div_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_div_prog;
    clear_mem();
    mem[0] = 8'hC3; mem[1] = 8'hDB; mem[2] = 8'hC1; mem[3] = 8'h08;
    mem[4] = 8'hC4; mem[5] = 8'h93; mem[6] = 8'hA0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b0; div_complete = 1'b0; Q = '0;
    clear_mem();
    @(negedge clock);
    checks++;
    if ({mem_req, mem_write, div_start, halted, illegal} !== 5'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_write, div_start, halted, illegal}); end
    checks++;
    if ({address, to_mem, dA, dB, A} !== 40'h0)
      begin errors++; $display("FAIL reset_data: got %h expected 0", {address, to_mem, dA, dB, A}); end
    checks++;
    if (S !== 3'd7) begin errors++; $display("FAIL reset_ir: S=%0d expected 7", S); end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL first_req_early: mem_req=%b expected 0", mem_req); end
    @(posedge clock); #1;
    checks++;
    if ({mem_req, address} !== {1'b1, 8'h00})
      begin errors++; $display("FAIL first_req: got %b/%h expected 1/00", mem_req, address); end
  endtask

  task automatic test_program;
    int base;
    clear_mem();
    mem[0] = 8'hC5; mem[1] = 8'hD9; mem[2] = 8'h01;
    do_reset();
    base = obs_rd.size();
    for (int k = 0; k < 3; k++) exp_q.push_back(16'(k));
    @(posedge clock);
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if ({address, A, B, mem_req} !== {8'd3, 8'd10, 8'd5, 1'b1})
      begin errors++; $display("FAIL program: pc=%h acc=%h r1=%h req=%b expected 03 0a 05 1", address, A, B, mem_req); end
    for (int k = 0; k < 3; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_rd.size() <= base + k || obs_rd[base+k] !== e)
        begin errors++; $display("FAIL program_fetch%0d: got %h expected %h", k, (obs_rd.size() > base + k) ? obs_rd[base+k] : 16'hxxxx, e); end
    end
  endtask

  task automatic test_stall;
    int base;
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'hF0;
    do_reset();
    mem_ready = 1'b0;
    base = obs_rd.size();
    @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if ({mem_req, address} !== {1'b1, 8'h00})
        begin errors++; $display("FAIL stall_c%0d: got %b/%h expected 1/00", c, mem_req, address); end
    end
    mem_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_exec: mem_req=%b expected 0", mem_req); end
    @(posedge clock); #1;
    checks++;
    if ({mem_req, address} !== {1'b1, 8'h01})
      begin errors++; $display("FAIL stall_next: got %b/%h expected 1/01", mem_req, address); end
    checks++;
    if (obs_rd.size() != base + 1) begin errors++; $display("FAIL stall_count: got %0d expected 1", obs_rd.size() - base); end
  endtask

  task automatic test_branch;
    int base;
    bit ok;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 8'hF0;
    mem[4] = 8'h5E;
    do_reset();
    base = obs_rd.size();
    exp_q.push_back(16'h00); exp_q.push_back(16'h01); exp_q.push_back(16'h02); exp_q.push_back(16'h03);
    exp_q.push_back(16'h04); exp_q.push_back(16'h03); exp_q.push_back(16'h04); exp_q.push_back(16'h03);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (obs_rd.size() >= base + 8) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bz_timeout: fetches=%0d expected 8", obs_rd.size() - base); end
    for (int k = 0; k < 8 && ok; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_rd[base+k] !== e) begin errors++; $display("FAIL bz_fetch%0d: got %h expected %h", k, obs_rd[base+k], e); end
    end
    // BNN with a negative accumulator must fall through
    clear_mem();
    mem[0] = 8'hF0; mem[1] = 8'hF0; mem[2] = 8'hC8; mem[3] = 8'h08; mem[4] = 8'h6E;
    do_reset();
    base = obs_rd.size();
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(16'(k));
    wait_halt(60, ok);
    checks++;
    if (!ok || A !== 8'h80) begin errors++; $display("FAIL bnn_end: halted=%b acc=%h expected 1/80", halted, A); end
    checks++;
    if (obs_rd.size() != base + 6) begin errors++; $display("FAIL bnn_count: got %0d expected 6", obs_rd.size() - base); end
    for (int k = 0; k < 6 && obs_rd.size() >= base + 6; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_rd[base+k] !== e) begin errors++; $display("FAIL bnn_fetch%0d: got %h expected %h", k, obs_rd[base+k], e); end
    end
  endtask

  task automatic test_ldst;
    int rb, wb;
    bit ok;
    logic [15:0] e;
    clear_mem();
    mem[0] = 8'hC1; mem[1] = 8'h08; mem[2] = 8'hDA; mem[3] = 8'hC2;
    mem[4] = 8'h08; mem[5] = 8'hCA; mem[6] = 8'hEA; mem[7] = 8'hE2;
    mem[8'h10] = 8'h33;
    do_reset();
    rb = obs_rd.size(); wb = obs_wr.size();
    exp_q.push_back({8'h10, 8'h2A});
    wait_halt(80, ok);
    checks++;
    if (!ok || A !== 8'h33) begin errors++; $display("FAIL ld_acc: halted=%b acc=%h expected 1/33", halted, A); end
    e = exp_q.pop_front();
    checks++;
    if (obs_wr.size() != wb + 1 || obs_wr[wb] !== e)
      begin errors++; $display("FAIL st_write: count=%0d first=%h expected 1/%h", obs_wr.size() - wb, (obs_wr.size() > wb) ? obs_wr[wb] : 16'hxxxx, e); end
    checks++;
    if (obs_rd.size() != rb + 10 || obs_rd[rb+8] !== 16'h0010 || obs_rd[rb+9] !== 16'h0008)
      begin errors++; $display("FAIL ld_read: count=%0d expected 10 with load at 10 then fetch 08", obs_rd.size() - rb); end
  endtask

  task automatic test_div;
    int s0;
    bit ok;
    load_div_prog();
    do_reset();
    s0 = n_start;
    exp_q.push_back({8'd20, 8'd3});
    wait_div(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div_start_timeout: div_start=%b expected 1", div_start); end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      checks++;
      if ({dA, dB, div_start} !== {exp_q[0], 1'b0})
        begin errors++; $display("FAIL div_hold_c%0d: got %h/%h/%b expected %h/0", c, dA, dB, div_start, exp_q[0]); end
      if (c == 5) begin div_complete = 1'b1; Q = 8'd6; end
    end
    @(negedge clock);
    div_complete = 1'b0; Q = '0;
    wait_halt(40, ok);
    void'(exp_q.pop_front());
    checks++;
    if (!ok || A !== 8'd6) begin errors++; $display("FAIL div_result: halted=%b acc=%h expected 1/06", halted, A); end
    checks++;
    if (n_start - s0 != 1) begin errors++; $display("FAIL div_pulse: got %0d cycles expected 1", n_start - s0); end
  endtask

  task automatic test_div_immediate;
    int s0;
    bit ok;
    load_div_prog();
    do_reset();
    div_complete = 1'b1; Q = 8'd6;
    s0 = n_start;
    exp_q.push_back({8'd20, 8'd3});
    wait_halt(40, ok);
    checks++;
    if (!ok || A !== 8'd6 || n_start - s0 != 1)
      begin errors++; $display("FAIL div_same_cycle: halted=%b acc=%h pulses=%0d expected 1/06/1", halted, A, n_start - s0); end
    checks++;
    if ({dA, dB} !== exp_q.pop_front()) begin errors++; $display("FAIL div_operands: got %h/%h expected 14/03", dA, dB); end
    div_complete = 1'b0; Q = '0;
  endtask

  task automatic test_halt;
    int base, reqs;
    bit ok;
    clear_mem();
    do_reset();
    base = obs_rd.size();
    wait_halt(20, ok);
    checks++;
    if (!ok || illegal !== 1'b0) begin errors++; $display("FAIL hlt: halted=%b illegal=%b expected 1/0", halted, illegal); end
    reqs = 0;
    repeat (10) begin @(negedge clock); if (mem_req) reqs++; end
    checks++;
    if (reqs != 0 || obs_rd.size() != base + 1)
      begin errors++; $display("FAIL hlt_quiet: req cycles=%0d fetches=%0d expected 0/1", reqs, obs_rd.size() - base); end
    clear_mem();
    mem[0] = 8'h80;
    do_reset();
    wait_halt(20, ok);
    checks++;
    if (!ok || {halted, illegal} !== 2'b11) begin errors++; $display("FAIL illegal: got %b%b expected 11", halted, illegal); end
  endtask

  task automatic test_reset_mid_div;
    bit ok;
    load_div_prog();
    do_reset();
    wait_div(40, ok);
    checks++;
    if (!ok || dA !== 8'd20) begin errors++; $display("FAIL mid_div_entry: div_start=%b dA=%h expected 1/14", div_start, dA); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_write, div_start, halted, illegal, address, to_mem, dA, dB, A} !== 45'h0)
      begin errors++; $display("FAIL mid_div_reset: got %h expected 0", {mem_req, mem_write, div_start, halted, illegal, address, to_mem, dA, dB, A}); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({mem_req, address, A} !== {1'b1, 8'h00, 8'h00})
      begin errors++; $display("FAIL mid_div_restart: got %b/%h/%h expected 1/00/00", mem_req, address, A); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program();
    test_stall();
    test_branch();
    test_ldst();
    test_div();
    test_div_immediate();
    test_halt();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 Parameter WIDTH, default 8: datapath, address and register width, minimum 8.
REQ-002 Parameter RESET_PC, default 0: program counter (r7) value after reset.
REQ-003 Ports, in this order:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- address  out  WIDTH  memory address.
- from_mem  in  WIDTH  memory read data.
- to_mem  out  WIDTH  memory write data.
- mem_req  out  1  memory request.
- mem_write  out  1  request is a write.
- mem_ready  in  1  request accepted/completed this cycle.
- A, B  out  WIDTH  ALU operands.
- S  out  3  ALU select.
- D  in  WIDTH  ALU result.
- dA, dB  out  WIDTH  divider dividend/divisor.
- div_start  out  1  divider start pulse.
- Q  in  WIDTH  divider quotient.
- div_complete  in  1  quotient valid.
- halted  out  1  core stopped.
- illegal  out  1  stop was caused by an undefined opcode.

Function
REQ-004 State: accumulator acc; register file r0..r7, each WIDTH bits, where r7 is the PC; instruction register ir, 8 bits.
REQ-005 FSM states: FETCH, EXEC, MEM, DIV, HALT.
REQ-006 FETCH:
- mem_req=1, mem_write=0, address=r7.
- On mem_ready=1: ir<=from_mem[7:0], r7<=r7+1 (mod 2^WIDTH), go to EXEC.
- Otherwise stay in FETCH with all outputs stable.
REQ-007 Requests: address, to_mem and mem_write stay constant while mem_req=1 and mem_ready=0; zero-wait (mem_ready already high) is legal.
REQ-008 Combinational outputs: A=acc; B=r[ir[2:0]]; S=ir[5:3]; dA and dB are the registered copies defined in REQ-016.
REQ-009 Decode in EXEC, using ir[7:4]; idx=ir[2:0]; off=ir[3:0] sign-extended to WIDTH. All of the following return to FETCH unless stated:
- 0000-0011 ALU: acc<=D.
- 0100 B: r7<=r7+off.
- 0101 BZ: same update, only if acc==0.
- 0110 BNN: same update, only if acc[WIDTH-1]==0.
- 1001 DIV: go to DIV.
- 1010 HLT: go to HALT.
- 1100 SET: acc[3:0]<=ir[3:0]; upper bits unchanged.
- 1101 MOV: ir[3]=1 gives r[idx]<=acc; otherwise acc<=r[idx].
- 1110 LD/ST: go to MEM.
- 1111 NOP: no state change.
REQ-010 Branch offset is relative to the already-incremented PC; the target wraps mod 2^WIDTH.
REQ-011 MOV to r7 is an absolute jump; the next fetch comes from acc.
REQ-012 Undefined opcodes (0111, 1000, 1011) cause illegal<=1 and a transition to HALT.
REQ-013 MEM:
- mem_req=1, address=r[idx], mem_write=ir[3], to_mem=acc when ir[3]=1.
- On mem_ready=1: a load (ir[3]=0) sets acc<=from_mem, then go to FETCH.
REQ-014 DIV, first cycle: div_start=1 for exactly one cycle, registered.
REQ-015 DIV, on div_complete=1: acc<=Q, then go to FETCH. Otherwise wait indefinitely.
REQ-016 dA and dB are latched from acc and r[idx] on entry to DIV and held for the whole of DIV.
REQ-017 div_complete arriving in the same cycle as div_start is accepted.
REQ-018 HALT: halted=1, mem_req=0, no state changes; only reset leaves HALT.
REQ-019 Instruction cost: minimum 2 cycles (FETCH+EXEC); LD/ST minimum 3; DIV minimum 3.
REQ-020 Simultaneous writes: r7 updates in EXEC override the FETCH increment because they occur in different states; there is never a double write.

Reset
REQ-021 While reset=1, asynchronously:
- state=FETCH, r7=RESET_PC, r0..r6=0, acc=0, ir=8'hFF.
- mem_req=0, mem_write=0, address=RESET_PC, to_mem=0, div_start=0, dA=0, dB=0, halted=0, illegal=0.
REQ-022 Reset mid-transaction or mid-divide abandons the operation; no register is written from it.
REQ-023 First fetch: mem_req rises on the first rising edge after reset deasserts, at address RESET_PC.

Verification
REQ-024 Program C5, D9, 01 with an adding ALU model and zero-wait memory -> r1=5, acc=10, PC=3 after 6 cycles.
REQ-025 mem_ready held low for 3 cycles during a fetch -> mem_req and address constant, r7 unchanged until the accepting edge.
REQ-026 acc=0 and 0x5E fetched at 0x04 -> next fetch address 0x03. acc=0x80 with BNN -> not taken, next fetch 0x05.
REQ-027 acc=0x2A, r2=0x10, ST 0xEA then LD 0xE2 with memory returning 0x33 -> write cycle at address 0x10 with data 0x2A; then acc=0x33.
REQ-028 acc=20, r3=3, DIV 0x93, div_complete after 5 cycles with Q=6 -> div_start high for exactly 1 cycle, dA=20, dB=3 stable, acc=6.
REQ-029 HLT 0xA0 -> halted=1, no further mem_req. Opcode 0x80 -> halted=1, illegal=1. Reset asserted mid-DIV -> all outputs at reset values with no clock edge.
